// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: arctangent table (pi = 2^31), inverse gain and FSM states.
// Used with or without the CORDIC_GAIN_COMP_EN build option.
package cordic_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      COMP = 2'd2
   } state_t;

   // 1/K in Q1.15, applied only when gain compensation is built in
   localparam logic signed [15:0] KINV = 16'sd19899;

   // Entry i holds atan(2^-i) scaled so that pi = 2^31, rounded to nearest
   localparam logic signed [31:0] ATAN_TABLE [0:31] = '{
      32'sh20000000, 32'sh12E4051E, 32'sh09FB385B, 32'sh051111D4,
      32'sh028B0D43, 32'sh0145D7E1, 32'sh00A2F61E, 32'sh00517C55,
      32'sh0028BE53, 32'sh00145F2F, 32'sh000A2F98, 32'sh000517CC,
      32'sh00028BE6, 32'sh000145F3, 32'sh0000A2FA, 32'sh0000517D,
      32'sh000028BE, 32'sh0000145F, 32'sh00000A30, 32'sh00000518,
      32'sh0000028C, 32'sh00000146, 32'sh000000A3, 32'sh00000051,
      32'sh00000029, 32'sh00000014, 32'sh0000000A, 32'sh00000005,
      32'sh00000003, 32'sh00000001, 32'sh00000001, 32'sh00000000
   };

endpackage

// File: rtl/cordic_iter_if.sv
// Request/result bundle for the iterative CORDIC engine.
// The master side issues operations; the slave side is the engine.
interface cordic_iter_if #(parameter int WIDTH = 32);

   logic                    i_start;
   logic                    i_mode;
   logic signed [WIDTH-1:0] i_x_in;
   logic signed [WIDTH-1:0] i_y_in;
   logic signed [WIDTH-1:0] i_z_in;
   logic                    o_busy;
   logic                    o_done;
   logic signed [WIDTH-1:0] o_x_out;
   logic signed [WIDTH-1:0] o_y_out;
   logic signed [WIDTH-1:0] o_z_out;

   modport master (
      output i_start, i_mode, i_x_in, i_y_in, i_z_in,
      input  o_busy, o_done, o_x_out, o_y_out, o_z_out
   );

   modport slave (
      input  i_start, i_mode, i_x_in, i_y_in, i_z_in,
      output o_busy, o_done, o_x_out, o_y_out, o_z_out
   );

endinterface

// File: rtl/cordic_microrot.sv
// One combinational CORDIC micro-rotation: picks the direction from z (rotation)
// or from the sign of y (vectoring), then applies the shift-add update with wrap-around.
module cordic_microrot #(
   parameter int WIDTH = 32
) (
   input  logic                    i_mode,
   input  logic signed [WIDTH-1:0] i_x,
   input  logic signed [WIDTH-1:0] i_y,
   input  logic signed [WIDTH-1:0] i_z,
   input  logic [4:0]              i_shift,
   input  logic signed [WIDTH-1:0] i_atan,
   output logic signed [WIDTH-1:0] o_x,
   output logic signed [WIDTH-1:0] o_y,
   output logic signed [WIDTH-1:0] o_z
);

   logic                    w_sigma_pos;
   logic signed [WIDTH-1:0] w_x_shift;
   logic signed [WIDTH-1:0] w_y_shift;

   assign w_sigma_pos = (!i_mode && !i_z[WIDTH-1]) || (i_mode && i_y[WIDTH-1]);
   assign w_x_shift   = i_x >>> i_shift;
   assign w_y_shift   = i_y >>> i_shift;

   assign o_x = w_sigma_pos ? (i_x - w_y_shift) : (i_x + w_y_shift);
   assign o_y = w_sigma_pos ? (i_y + w_x_shift) : (i_y - w_x_shift);
   assign o_z = w_sigma_pos ? (i_z - i_atan)    : (i_z + i_atan);

endmodule

// File: rtl/cordic_iter.sv
// Iterative CORDIC engine, one micro-rotation per clock, ITER steps per operation.
// Build option CORDIC_GAIN_COMP_EN adds a final cycle that scales x/y by 1/K.
module cordic_iter
   import cordic_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int ITER  = 16
) (
   input logic          clk,
   input logic          rst_n,
   cordic_iter_if.slave bus
);

   localparam logic [5:0] LAST_ITER = 6'(ITER - 1);

   state_t                  r_state;
   state_t                  w_next_state;
   logic                    r_mode;
   logic signed [WIDTH-1:0] r_x;
   logic signed [WIDTH-1:0] r_y;
   logic signed [WIDTH-1:0] r_z;
   logic [5:0]              r_iter;
   logic                    r_done;
   logic signed [WIDTH-1:0] r_x_out;
   logic signed [WIDTH-1:0] r_y_out;
   logic signed [WIDTH-1:0] r_z_out;

   logic                    w_last;
   logic signed [31:0]      w_atan32;
   logic signed [WIDTH-1:0] w_atan;
   logic signed [WIDTH-1:0] w_x_rot;
   logic signed [WIDTH-1:0] w_y_rot;
   logic signed [WIDTH-1:0] w_z_rot;

   assign w_last   = (r_iter == LAST_ITER);
   assign w_atan32 = ATAN_TABLE[r_iter[4:0]];
   assign w_atan   = WIDTH'(w_atan32 >>> (32 - WIDTH));

   cordic_microrot #(.WIDTH(WIDTH)) u_microrot (
      .i_mode  (r_mode),
      .i_x     (r_x),
      .i_y     (r_y),
      .i_z     (r_z),
      .i_shift (r_iter[4:0]),
      .i_atan  (w_atan),
      .o_x     (w_x_rot),
      .o_y     (w_y_rot),
      .o_z     (w_z_rot)
   );

`ifdef CORDIC_GAIN_COMP_EN
   localparam int PW = WIDTH + 16;
   logic signed [WIDTH-1:0] w_x_comp;
   logic signed [WIDTH-1:0] w_y_comp;

   assign w_x_comp = WIDTH'((PW'(r_x) * PW'(KINV)) >>> 15);
   assign w_y_comp = WIDTH'((PW'(r_y) * PW'(KINV)) >>> 15);
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: if (bus.i_start) w_next_state = RUN;
`ifdef CORDIC_GAIN_COMP_EN
         RUN:  if (w_last) w_next_state = COMP;
`else
         RUN:  if (w_last) w_next_state = IDLE;
`endif
         COMP: w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Working registers and result registers; done is a single-cycle strobe
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mode  <= 1'b0;
         r_x     <= '0;
         r_y     <= '0;
         r_z     <= '0;
         r_iter  <= '0;
         r_done  <= 1'b0;
         r_x_out <= '0;
         r_y_out <= '0;
         r_z_out <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.i_start) begin
                  r_mode <= bus.i_mode;
                  r_x    <= bus.i_x_in;
                  r_y    <= bus.i_y_in;
                  r_z    <= bus.i_z_in;
                  r_iter <= '0;
               end
            end
            RUN: begin
               r_x    <= w_x_rot;
               r_y    <= w_y_rot;
               r_z    <= w_z_rot;
               r_iter <= r_iter + 6'd1;
`ifndef CORDIC_GAIN_COMP_EN
               if (w_last) begin
                  r_x_out <= w_x_rot;
                  r_y_out <= w_y_rot;
                  r_z_out <= w_z_rot;
                  r_done  <= 1'b1;
               end
`endif
            end
`ifdef CORDIC_GAIN_COMP_EN
            COMP: begin
               r_x     <= w_x_comp;
               r_y     <= w_y_comp;
               r_x_out <= w_x_comp;
               r_y_out <= w_y_comp;
               r_z_out <= r_z;
               r_done  <= 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

   assign bus.o_busy  = (r_state != IDLE);
   assign bus.o_done  = r_done;
   assign bus.o_x_out = r_x_out;
   assign bus.o_y_out = r_y_out;
   assign bus.o_z_out = r_z_out;

endmodule

// File: tb/tb_cordic_iter.sv
// Directed bench for cordic_iter (WIDTH=32, ITER=16); expectations follow
// CORDIC_GAIN_COMP_EN when the bench is built with it.
module tb_cordic_iter;

   localparam int    WIDTH = 32;
   localparam int    ITER  = 16;
   localparam longint TOL  = 64'sd65536;
`ifdef CORDIC_GAIN_COMP_EN
   localparam int     EXP_LAT  = ITER + 1;
   localparam longint EXP_45   = 64'sd379625062;
   localparam longint EXP_FULL = 64'sd536870912;
`else
   localparam int     EXP_LAT  = ITER;
   localparam longint EXP_45   = 64'sd625151280;
   localparam longint EXP_FULL = 64'sd884097622;
`endif

   logic clk;
   logic rst_n;
   int   checkCount;
   int   failCount;

   cordic_iter_if #(.WIDTH(WIDTH)) bus ();

   cordic_iter #(.WIDTH(WIDTH), .ITER(ITER)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every comparison funnels through here; tol=0 means exact match
   task automatic checkOutput(input string tag, input longint observed,
                              input longint expected, input longint tol);
      longint diff;
      checkCount++;
      diff = observed - expected;
      if (diff < 0) diff = -diff;
      if (diff > tol) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d expected %0d (tol %0d)", tag, observed, expected, tol);
      end
   endtask

   // Holds start for exactly one rising edge, returns #1 after that edge
   task automatic applyStimulus(input logic mode, input logic [31:0] x,
                                input logic [31:0] y, input logic [31:0] z);
      bus.i_start = 1'b1;
      bus.i_mode  = mode;
      bus.i_x_in  = x;
      bus.i_y_in  = y;
      bus.i_z_in  = z;
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
   endtask

   task automatic waitDone(output int cycles);
      cycles = -1;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk);
         #1;
         if (bus.o_done) begin
            cycles = n;
            break;
         end
      end
   endtask

   task automatic checkResult(input string tag, input longint ex, input longint ey,
                              input longint ez);
      checkOutput({tag, "_x"}, longint'(bus.o_x_out), ex, TOL);
      checkOutput({tag, "_y"}, longint'(bus.o_y_out), ey, TOL);
      checkOutput({tag, "_z"}, longint'(bus.o_z_out), ez, TOL);
   endtask

   initial begin
      int cycles;
      int doneSeen;
      int firstDone;
      longint capY;
      longint capZ;

      checkCount  = 0;
      failCount   = 0;
      rst_n       = 1'b0;
      bus.i_start = 1'b0;
      bus.i_mode  = 1'b0;
      bus.i_x_in  = '0;
      bus.i_y_in  = '0;
      bus.i_z_in  = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_busy", longint'(bus.o_busy), 0, 0);
      checkOutput("rst_done", longint'(bus.o_done), 0, 0);
      checkResult("rst", 0, 0, 0);
      rst_n = 1'b1;

      // Rotation by +pi/4
      applyStimulus(1'b0, 32'h2000_0000, 32'h0, 32'h2000_0000);
      checkOutput("rot45_busy", longint'(bus.o_busy), 1, 0);
      waitDone(cycles);
      checkOutput("rot45_lat", cycles, EXP_LAT, 0);
      checkResult("rot45", EXP_45, EXP_45, 0);

      // Vectoring from (1,1)
      applyStimulus(1'b1, 32'h1000_0000, 32'h1000_0000, 32'h0);
      waitDone(cycles);
      checkOutput("vec45_lat", cycles, EXP_LAT, 0);
      checkResult("vec45", EXP_45, 0, 64'sd536870912);

      // Rotation by -pi/4
      applyStimulus(1'b0, 32'h2000_0000, 32'h0, 32'hE000_0000);
      waitDone(cycles);
      checkResult("rotm45", EXP_45, -EXP_45, 0);

      // Vectoring from (1,-1)
      applyStimulus(1'b1, 32'h1000_0000, 32'hF000_0000, 32'h0);
      waitDone(cycles);
      checkResult("vecm45", EXP_45, 0, -64'sd536870912);

      // Zero angle: only the gain (or its compensation) shows up
      applyStimulus(1'b0, 32'h2000_0000, 32'h0, 32'h0);
      waitDone(cycles);
      checkOutput("rot0_lat", cycles, EXP_LAT, 0);
      checkResult("rot0", EXP_FULL, 0, 0);

      // A start while busy must not disturb the operation in flight
      applyStimulus(1'b0, 32'h2000_0000, 32'h0, 32'h2000_0000);
      doneSeen  = 0;
      firstDone = -1;
      capY      = 0;
      capZ      = 0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         #1;
         bus.i_start = 1'b0;
         if (bus.o_done) begin
            doneSeen++;
            if (firstDone < 0) begin
               firstDone = n;
               capY      = longint'(bus.o_y_out);
               capZ      = longint'(bus.o_z_out);
            end
         end
         if (n == 4) begin
            bus.i_start = 1'b1;
            bus.i_mode  = 1'b1;
            bus.i_x_in  = 32'h1000_0000;
            bus.i_y_in  = 32'h1000_0000;
            bus.i_z_in  = 32'h0;
         end
      end
      checkOutput("ign_dones", doneSeen, 1, 0);
      checkOutput("ign_lat", firstDone, EXP_LAT, 0);
      checkOutput("ign_y", capY, EXP_45, TOL);
      checkOutput("ign_z", capZ, 0, TOL);

      // Back-to-back: issue the next start during the done cycle
      applyStimulus(1'b0, 32'h2000_0000, 32'h0, 32'h2000_0000);
      waitDone(cycles);
      checkOutput("b2b_lat1", cycles, EXP_LAT, 0);
      applyStimulus(1'b1, 32'h1000_0000, 32'h1000_0000, 32'h0);
      waitDone(cycles);
      checkOutput("b2b_lat2", cycles, EXP_LAT, 0);
      checkResult("b2b", EXP_45, 0, 64'sd536870912);

      // Reset pulse in the middle of an operation
      applyStimulus(1'b0, 32'h2000_0000, 32'h0, 32'h2000_0000);
      repeat (7) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      checkOutput("mrst_busy", longint'(bus.o_busy), 0, 0);
      checkOutput("mrst_done", longint'(bus.o_done), 0, 0);
      checkResult("mrst", 0, 0, 0);
      doneSeen = 0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         #1;
         if (bus.o_done) doneSeen++;
      end
      checkOutput("mrst_nodone", doneSeen, 0, 0);
      applyStimulus(1'b0, 32'h2000_0000, 32'h0, 32'h2000_0000);
      waitDone(cycles);
      checkOutput("post_lat", cycles, EXP_LAT, 0);
      checkResult("post", EXP_45, EXP_45, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
